exec_hazard_ctrl: RTL and testbench
===================================

// Module: exec_hazard_ctrl
// PURPOSE
//  Hazard/forwarding controller for the execute stage. Keeps shadow copies of the
//  EX/M/WB register destinations and generates registered forwarding selects for
//  both ALU operands. Also generates the load-use stall and the RET drain/flush
//  sequence. Sits beside decode; its outputs drive the execute-stage forwarding
//  muxes and the IF/ID latch enable/flush.
// PARAMETERS
//  REG_AW            2  register address width (4 GPRs)
//  RET_FLUSH_CYCLES  3  cycles of front-end flush after a RET enters EX (>=1)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  id_valid    in   1       decode holds a real instruction
//  id_src_a    in   REG_AW  operand-A source register
//  id_use_a    in   1       operand A read from the register file
//  id_src_b    in   REG_AW  operand-B source register
//  id_use_b    in   1       operand B read from the register file (not PC/imm)
//  id_dest     in   REG_AW  destination register
//  id_wen      in   1       instruction writes id_dest
//  id_memrd    in   1       instruction is a load (result valid only at WB)
//  id_ret      in   1       instruction is RET
//  fwd_a_en    out  1       1: ALU A takes forwarded data; 0: data_out1EX
//  fwd_a_wb    out  1       forwarded source for A: 1 = WB_data, 0 = ALU_resultM
//  fwd_b_en    out  1       1: ALU B takes forwarded data; 0: normal B path
//  fwd_b_wb    out  1       forwarded source for B: 1 = WB_data, 0 = ALU_resultM
//  stall_fd    out  1       hold PC and the IF/ID latch this cycle
//  flush_fd    out  1       squash the IF/ID contents (RET drain)
//  bubble_ex   out  1       load a NOP into ID/EX at the next edge
// BEHAVIOUR
//  - Shadow slots EX, M, WB each hold {valid, dest, wen, memrd}. They advance
//    ID->EX->M->WB on every edge. EX takes a bubble (valid=0) whenever
//    bubble_ex=1 or id_valid=0.
//  - "Producer X matches src s": X.valid & X.wen & X.dest==s.
//  - Forwarding is computed from ID vs the current shadows and registered, so the
//    values apply while that instruction sits in EX (zero combinational path
//    into EX):
//      EX matches and !EX.memrd -> en=1, wb=0 (ALU_resultM next cycle)
//      else M matches           -> en=1, wb=1 (WB_data next cycle, ALU or load)
//      else                     -> en=0, wb=0
//    EX has priority over M (youngest producer wins). When id_use_x=0, that
//    operand's selects are 0. On a bubble, all four selects register to 0.
//  - Load-use: id_valid & EX matches (id_use_a,id_src_a or id_use_b,id_src_b) &
//    EX.memrd. Effect: stall_fd=1 and bubble_ex=1 for exactly one cycle
//    (combinational, from ID + EX shadow). The next cycle the load is in M, so
//    the retried instruction registers wb=1.
//  - FSM states: RUN, RET_DRAIN.
//      RUN -> RET_DRAIN when an RET is accepted into EX (id_valid & id_ret &
//        !stall_fd). The down-counter loads RET_FLUSH_CYCLES.
//      RET_DRAIN: flush_fd=1 and bubble_ex=1. The counter decrements each cycle.
//        At counter==1 the FSM returns to RUN. flush_fd is high for exactly
//        RET_FLUSH_CYCLES cycles.
//      A load-use stall in RUN takes precedence over a RET in ID: the RET is
//      accepted on the retry cycle.
//  - Output reset values (applied asynchronously): all fwd_* = 0, stall_fd = 0,
//    flush_fd = 0, bubble_ex = 0. All shadow valid bits = 0, FSM = RUN,
//    counter = 0.
//  - Reset asserted mid-RET_DRAIN aborts the drain. On release the FSM is in RUN
//    with empty shadows.
//  - All address comparisons are exactly REG_AW bits wide. There is no zero
//    register: R0 participates in hazards.
// TESTING
//  1. ADD R1<-R2,R3 then ADD R0<-R1,R2 back-to-back -> 2nd in EX: fwd_a_en=1,
//     fwd_a_wb=0, fwd_b_en=0.
//  2. ADD R1<-..., NOP, SUB R2<-R0,R1 (use_b) -> SUB in EX: fwd_b_en=1,
//     fwd_b_wb=1.
//  3. ADD R2<-..., ADD R2<-..., OR R3<-R2,R2 -> OR in EX: both en=1, wb=0
//     (youngest wins).
//  4. LD R3<-[R0] then ADD R1<-R1,R3 -> stall_fd=1 and bubble_ex=1 for one cycle.
//     Then ADD in EX with fwd_b_en=1, fwd_b_wb=1.
//  5. RET with RET_FLUSH_CYCLES=3 -> flush_fd=1 for exactly 3 cycles after RET
//     enters EX. The next ID instruction issues on the 4th cycle.
//  6. rst pulsed during the 2nd RET_DRAIN cycle -> all outputs 0 immediately,
//     before the next clock edge. After release: RUN, no forwarding to the
//     pre-reset producers.

Source files
------------

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage hazard controller: registered operand forwarding selects,
// load-use stall, and the RET drain/flush sequence for the IF/ID latch.
module exec_hazard_ctrl #(
   parameter int REG_AW           = 2,
   parameter int RET_FLUSH_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src_a,
   input  logic              id_use_a,
   input  logic [REG_AW-1:0] id_src_b,
   input  logic              id_use_b,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wen,
   input  logic              id_memrd,
   input  logic              id_ret,
   output logic              fwd_a_en,
   output logic              fwd_a_wb,
   output logic              fwd_b_en,
   output logic              fwd_b_wb,
   output logic              stall_fd,
   output logic              flush_fd,
   output logic              bubble_ex,
   output logic              dbg_state,
   output logic [REG_AW+2:0] dbg_wb_slot
);

   localparam logic [0:0] ST_RUN       = 1'b0;
   localparam logic [0:0] ST_RET_DRAIN = 1'b1;
   localparam int         CW           = $clog2(RET_FLUSH_CYCLES + 1);

   logic [0:0]        state;
   logic [CW-1:0]     cnt;

   logic              ex_valid, ex_wen, ex_memrd;
   logic [REG_AW-1:0] ex_dest;
   logic              m_valid, m_wen, m_memrd;
   logic [REG_AW-1:0] m_dest;
   logic              wb_valid, wb_wen, wb_memrd;
   logic [REG_AW-1:0] wb_dest;

   logic ex_hit_a, ex_hit_b, m_hit_a, m_hit_b;
   logic load_use, in_drain, issue, ret_accept;
   logic a_en_nxt, a_wb_nxt, b_en_nxt, b_wb_nxt;

   always_comb begin
      ex_hit_a   = ex_valid & ex_wen & (ex_dest == id_src_a);
      ex_hit_b   = ex_valid & ex_wen & (ex_dest == id_src_b);
      m_hit_a    = m_valid & m_wen & (m_dest == id_src_a);
      m_hit_b    = m_valid & m_wen & (m_dest == id_src_b);
      load_use   = id_valid & ex_memrd &
                   ((id_use_a & ex_hit_a) | (id_use_b & ex_hit_b));
      in_drain   = (state == ST_RET_DRAIN);
      stall_fd   = load_use;
      flush_fd   = in_drain;
      bubble_ex  = load_use | in_drain;
      issue      = id_valid & ~bubble_ex;
      ret_accept = (state == ST_RUN) & id_valid & id_ret & ~stall_fd;
      // A loaded value in EX is never forwarded from ALU_resultM; that case
      // is the load-use stall, so only a non-load EX producer wins here.
      a_en_nxt   = issue & id_use_a & ((ex_hit_a & ~ex_memrd) | m_hit_a);
      a_wb_nxt   = issue & id_use_a & ~(ex_hit_a & ~ex_memrd) & m_hit_a;
      b_en_nxt   = issue & id_use_b & ((ex_hit_b & ~ex_memrd) | m_hit_b);
      b_wb_nxt   = issue & id_use_b & ~(ex_hit_b & ~ex_memrd) & m_hit_b;
      dbg_state   = state;
      dbg_wb_slot = {wb_valid, wb_dest, wb_wen, wb_memrd};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid <= 1'b0; ex_wen <= 1'b0; ex_memrd <= 1'b0; ex_dest <= '0;
         m_valid  <= 1'b0; m_wen  <= 1'b0; m_memrd  <= 1'b0; m_dest  <= '0;
         wb_valid <= 1'b0; wb_wen <= 1'b0; wb_memrd <= 1'b0; wb_dest <= '0;
         fwd_a_en <= 1'b0; fwd_a_wb <= 1'b0;
         fwd_b_en <= 1'b0; fwd_b_wb <= 1'b0;
      end else begin
         ex_valid <= issue;
         ex_wen   <= id_wen;
         ex_memrd <= id_memrd;
         ex_dest  <= id_dest;
         m_valid  <= ex_valid;
         m_wen    <= ex_wen;
         m_memrd  <= ex_memrd;
         m_dest   <= ex_dest;
         wb_valid <= m_valid;
         wb_wen   <= m_wen;
         wb_memrd <= m_memrd;
         wb_dest  <= m_dest;
         fwd_a_en <= a_en_nxt;
         fwd_a_wb <= a_wb_nxt;
         fwd_b_en <= b_en_nxt;
         fwd_b_wb <= b_wb_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (ret_accept) begin
                  state <= ST_RET_DRAIN;
                  cnt   <= CW'(RET_FLUSH_CYCLES);
               end
            end
            default: begin
               if (cnt == CW'(1)) state <= ST_RUN;
               cnt <= cnt - CW'(1);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl: each driven cycle queues its expected
// output vector; a negedge monitor pops and compares.
module tb_exec_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_a, id_use_b, id_wen, id_memrd, id_ret;
   logic [1:0] id_src_a, id_src_b, id_dest;
   logic       fwd_a_en, fwd_a_wb, fwd_b_en, fwd_b_wb;
   logic       stall_fd, flush_fd, bubble_ex, dbg_state;
   logic [4:0] dbg_wb_slot;

   // {wb_valid, a_en, a_wb, b_en, b_wb, stall, flush, bubble, state}
   logic [8:0] exp_q[$];
   string      name_q[$];
   logic [8:0] mon_got, mon_exp;
   string      mon_name;
   int         total = 0;
   int         bad   = 0;

   exec_hazard_ctrl #(.REG_AW(2), .RET_FLUSH_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_src_a(id_src_a), .id_use_a(id_use_a),
      .id_src_b(id_src_b), .id_use_b(id_use_b), .id_dest(id_dest),
      .id_wen(id_wen), .id_memrd(id_memrd), .id_ret(id_ret),
      .fwd_a_en(fwd_a_en), .fwd_a_wb(fwd_a_wb),
      .fwd_b_en(fwd_b_en), .fwd_b_wb(fwd_b_wb),
      .stall_fd(stall_fd), .flush_fd(flush_fd), .bubble_ex(bubble_ex),
      .dbg_state(dbg_state), .dbg_wb_slot(dbg_wb_slot)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_got  = {dbg_wb_slot[4], fwd_a_en, fwd_a_wb, fwd_b_en, fwd_b_wb,
                     stall_fd, flush_fd, bubble_ex, dbg_state};
         total++;
         if (mon_got !== mon_exp) begin
            bad++;
            $display("FAIL %s: got=%b required=%b", mon_name, mon_got, mon_exp);
         end
      end
   end

   task automatic issue(input string nm, input logic v,
                        input logic [1:0] sa, input logic ua,
                        input logic [1:0] sb, input logic ub,
                        input logic [1:0] d, input logic w,
                        input logic mr, input logic rt, input logic [8:0] e);
      id_valid = v;  id_src_a = sa; id_use_a = ua;
      id_src_b = sb; id_use_b = ub; id_dest  = d;
      id_wen   = w;  id_memrd = mr; id_ret   = rt;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input string nm, input logic [8:0] e);
      issue(nm, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, e);
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 1'b0; id_src_a = '0; id_use_a = 1'b0; id_src_b = '0;
      id_use_b = 1'b0; id_dest = '0; id_wen = 1'b0; id_memrd = 1'b0;
      id_ret = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(9'b0_0000_0000);
      name_q.push_back("reset_state");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // back-to-back ALU dependency -> forward from ALU_resultM
      issue("t1_add_r1", 1, 2'd2, 1, 2'd3, 1, 2'd1, 1, 0, 0, 9'b0_0000_0000);
      issue("t1_add_r0", 1, 2'd1, 1, 2'd2, 1, 2'd0, 1, 0, 0, 9'b0_0000_0000);
      nop("t1_fwd_a_m",      9'b0_1000_0000);
      nop("t1_drain1",       9'b1_0000_0000);
      nop("t1_drain2",       9'b1_0000_0000);
      // one-gap dependency on operand B -> forward from WB_data
      issue("t2_add_r1", 1, 2'd2, 1, 2'd3, 1, 2'd1, 1, 0, 0, 9'b0_0000_0000);
      nop("t2_gap",          9'b0_0000_0000);
      issue("t2_sub_r2", 1, 2'd0, 1, 2'd1, 1, 2'd2, 1, 0, 0, 9'b0_0000_0000);
      nop("t2_fwd_b_wb",     9'b1_0011_0000);
      // two writers of R2: youngest wins; unused operands never forward
      issue("t3_add_r2a", 1, 2'd0, 0, 2'd0, 0, 2'd2, 1, 0, 0, 9'b0_0000_0000);
      issue("t3_add_r2b", 1, 2'd2, 0, 2'd2, 0, 2'd2, 1, 0, 0, 9'b1_0000_0000);
      issue("t3_or_r3",   1, 2'd2, 1, 2'd2, 1, 2'd3, 1, 0, 0, 9'b0_0000_0000);
      nop("t3_youngest",     9'b1_1010_0000);
      // load-use: one stall/bubble cycle, then forward from WB_data
      issue("t4_ld_r3",   1, 2'd0, 1, 2'd0, 0, 2'd3, 1, 1, 0, 9'b1_0000_0000);
      issue("t4_stall",   1, 2'd1, 1, 2'd3, 1, 2'd1, 1, 0, 0, 9'b1_0000_1010);
      issue("t4_retry",   1, 2'd1, 1, 2'd3, 1, 2'd1, 1, 0, 0, 9'b0_0000_0000);
      nop("t4_fwd_b_wb",     9'b1_0011_0000);
      // RET: three flush cycles, held instruction issues on the fourth
      issue("t5_ret",     1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 1, 9'b0_0000_0000);
      issue("t5_flush1",  1, 2'd1, 1, 2'd0, 0, 2'd1, 1, 0, 0, 9'b1_0000_0111);
      issue("t5_flush2",  1, 2'd1, 1, 2'd0, 0, 2'd1, 1, 0, 0, 9'b0_0000_0111);
      issue("t5_flush3",  1, 2'd1, 1, 2'd0, 0, 2'd1, 1, 0, 0, 9'b1_0000_0111);
      issue("t5_issue",   1, 2'd1, 1, 2'd0, 0, 2'd1, 1, 0, 0, 9'b0_0000_0000);
      issue("t5_or_r0",   1, 2'd1, 1, 2'd0, 0, 2'd0, 1, 0, 0, 9'b0_0000_0000);
      nop("t5_fwd_after_ret", 9'b0_1000_0000);
      // reset during the second drain cycle
      issue("t6_ret",     1, 2'd0, 0, 2'd0, 0, 2'd0, 0, 0, 1, 9'b1_0000_0000);
      nop("t6_drain1",       9'b1_0000_0111);
      rst = 1'b1;
      issue("t6_async_rst", 1, 2'd0, 0, 2'd0, 0, 2'd0, 1, 0, 0, 9'b0_0000_0000);
      rst = 1'b0;
      issue("t6_after_rst", 1, 2'd0, 1, 2'd2, 1, 2'd3, 1, 0, 0, 9'b0_0000_0000);
      nop("t6_no_old_fwd",   9'b0_0000_0000);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got=%0d pending required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
